// File: rtl/nibble_frame_demux_if.sv
// nibble_frame_demux_if: beat-input and frame-output bus of the nibble frame demux.
//
// Handshake: a beat moves when in_valid & in_ready are both high on a rising clock
// edge; a frame moves when out_valid & out_ready are both high on a rising edge.
// A valid, once raised, holds its payload stable until the matching transfer.
// frame_err and busy are status outputs with no handshake.
interface nibble_frame_demux_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_sel;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [DATA_W-1:0] out_c;
    logic [DATA_W-1:0] out_d;
    logic              frame_err;
    logic              busy;

    // Demux side of the bus
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_c, out_d, frame_err, busy
    );

    // Source / consumer side of the bus
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_c, out_d, frame_err, busy
    );
endinterface

// File: rtl/nibble_frame_demux.sv
// nibble_frame_demux: rebuilds four parallel lanes a/b/c/d from a time-multiplexed
// (sel, nibble) beat stream. Beats must arrive in order 0,1,2,3; violations are
// reported with a one-cycle frame_err pulse. A shadow buffer collects the frame and
// a registered output slot presents it, so a new frame can be collected while the
// previous one waits for the consumer.
//
// Optional feature macro NFD_TIMEOUT_EN: when defined, a partial frame that sees
// TIMEOUT_CYC consecutive cycles without an accepted beat is discarded.
module nibble_frame_demux #(
    parameter int DATA_W      = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_frame_demux_if.slave  bus,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_exp;
    logic [1:0]        w_exp_nxt;
    logic [DATA_W-1:0] r_shadow     [4];
    logic [DATA_W-1:0] w_shadow_nxt [4];
    logic [DATA_W-1:0] r_out        [4];
    logic [DATA_W-1:0] w_out_nxt    [4];
    logic              r_out_valid;
    logic              w_out_valid_nxt;
    logic              r_frame_err;
    logic              w_frame_err_nxt;

    logic              w_accept;
    logic              w_slot_free;
    logic              w_timeout;

    // Beat acceptance and output-slot availability
    assign w_accept    = bus.in_valid & bus.in_ready;
    assign w_slot_free = ~r_out_valid | bus.out_ready;

`ifdef NFD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_idle_cnt;

    // Idle-cycle counter for a partial frame; restarts on every accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if ((r_state != S_COLLECT) || w_accept) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // The cycle that would complete TIMEOUT_CYC idle cycles triggers the discard
    assign w_timeout = (r_state == S_COLLECT) && !w_accept &&
                       (r_idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    // Without the timeout feature a partial frame waits indefinitely;
    // TIMEOUT_CYC has no effect in this build.
    assign w_timeout = 1'b0 & (TIMEOUT_CYC < 0);
`endif

    // State, expected-lane index, shadow and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_exp       <= 2'd0;
            r_shadow    <= '{default: '0};
            r_out       <= '{default: '0};
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp       <= w_exp_nxt;
            r_shadow    <= w_shadow_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Next-state, beat-order checking and frame hand-off
    always_comb begin
        w_state_nxt     = r_state;
        w_exp_nxt       = r_exp;
        w_shadow_nxt    = r_shadow;
        w_out_nxt       = r_out;
        // A presented frame leaves on transfer; loads below re-raise valid.
        w_out_valid_nxt = r_out_valid & ~bus.out_ready;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.in_sel == 2'd0) begin
                        w_shadow_nxt[0] = bus.in_data;
                        w_exp_nxt       = 2'd1;
                        w_state_nxt     = S_COLLECT;
                    end else begin
                        // Frame must start on lane 0; the beat is dropped.
                        w_frame_err_nxt = 1'b1;
                    end
                end
            end

            S_COLLECT: begin
                if (w_accept) begin
                    if (bus.in_sel == r_exp) begin
                        if (r_exp == 2'd3) begin
                            if (w_slot_free) begin
                                w_out_nxt[0]    = r_shadow[0];
                                w_out_nxt[1]    = r_shadow[1];
                                w_out_nxt[2]    = r_shadow[2];
                                w_out_nxt[3]    = bus.in_data;
                                w_out_valid_nxt = 1'b1;
                                w_exp_nxt       = 2'd0;
                                w_state_nxt     = S_IDLE;
                            end else begin
                                // Output slot still occupied: park the frame.
                                w_shadow_nxt[3] = bus.in_data;
                                w_state_nxt     = S_FULL;
                            end
                        end else begin
                            w_shadow_nxt[r_exp] = bus.in_data;
                            w_exp_nxt           = r_exp + 2'd1;
                        end
                    end else if (bus.in_sel == 2'd0) begin
                        // Lane 0 mid-frame starts a fresh frame.
                        w_shadow_nxt[0] = bus.in_data;
                        w_exp_nxt       = 2'd1;
                        w_frame_err_nxt = 1'b1;
                    end else begin
                        // Out-of-order lane: drop the beat and the partial frame.
                        w_frame_err_nxt = 1'b1;
                        w_exp_nxt       = 2'd0;
                        w_state_nxt     = S_IDLE;
                    end
                end else if (w_timeout) begin
                    w_frame_err_nxt = 1'b1;
                    w_exp_nxt       = 2'd0;
                    w_state_nxt     = S_IDLE;
                end
            end

            S_FULL: begin
                if (bus.out_ready) begin
                    w_out_nxt       = r_shadow;
                    w_out_valid_nxt = 1'b1;
                    w_exp_nxt       = 2'd0;
                    w_state_nxt     = S_IDLE;
                end
            end

            default: begin
                w_exp_nxt   = 2'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (r_state != S_FULL);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_a     = r_out[0];
    assign bus.out_b     = r_out[1];
    assign bus.out_c     = r_out[2];
    assign bus.out_d     = r_out[3];
    assign bus.frame_err = r_frame_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_nibble_frame_demux.sv
// tb_nibble_frame_demux: directed beat sequences for nibble_frame_demux with
// hand-computed frames, error-pulse counts and handshake states.
module tb_nibble_frame_demux;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  int n_tests;
  int n_fail;
  int err_cnt;
  int e0;

  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  nibble_frame_demux_if #(.DATA_W(4)) bus ();

  nibble_frame_demux #(.DATA_W(4), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_word();
    return {16'h0, bus.out_a, bus.out_b, bus.out_c, bus.out_d};
  endfunction

  // driver tasks
  task automatic beat(input logic [1:0] s, input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_sel   = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard: frames leaving the output slot, and frame_err pulse count
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_err) err_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        check("sb_q_has_entry", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          sb_exp = exp_q.pop_front();
          check("sb_frame", out_word(), sb_exp);
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = 4'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", out_word(), 32'h0000);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_state", 32'(dbg_state), 32'd0);

    // clean frame, back-to-back beats
    e0 = err_cnt;
    exp_q.push_back(32'h3591);
    beat(2'd0, 4'h3); beat(2'd1, 4'h5); beat(2'd2, 4'h9); beat(2'd3, 4'h1);
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check("t1_out", out_word(), 32'h3591);
    check("t1_busy", 32'(bus.busy), 32'd0);
    idle(1);
    check("t1_valid_one_cycle", 32'(bus.out_valid), 32'd0);
    check("t1_no_err", 32'(err_cnt - e0), 32'd0);

    // two frames with consumer stalled: second parks in FULL
    bus.out_ready = 1'b0;
    exp_q.push_back(32'hABCD);
    exp_q.push_back(32'h1234);
    beat(2'd0, 4'hA); beat(2'd1, 4'hB); beat(2'd2, 4'hC); beat(2'd3, 4'hD);
    check("t2_f1_valid", 32'(bus.out_valid), 32'd1);
    beat(2'd0, 4'h1); beat(2'd1, 4'h2); beat(2'd2, 4'h3); beat(2'd3, 4'h4);
    check("t2_full_in_ready", 32'(bus.in_ready), 32'd0);
    check("t2_full_state", 32'(dbg_state), 32'd2);
    check("t2_full_busy", 32'(bus.busy), 32'd1);
    check("t2_f1_out", out_word(), 32'hABCD);
    idle(2);
    check("t2_hold_out", out_word(), 32'hABCD);
    check("t2_hold_valid", 32'(bus.out_valid), 32'd1);
    check("t2_hold_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    idle(1);
    check("t2_f2_out", out_word(), 32'h1234);
    check("t2_f2_valid", 32'(bus.out_valid), 32'd1);
    check("t2_f2_in_ready", 32'(bus.in_ready), 32'd1);
    check("t2_f2_busy", 32'(bus.busy), 32'd0);
    idle(1);
    check("t2_drained", 32'(bus.out_valid), 32'd0);

    // skipped lane: (0,1)(2,7) drops the partial frame
    e0 = err_cnt;
    beat(2'd0, 4'h1); beat(2'd2, 4'h7);
    check("t3_err", 32'(bus.frame_err), 32'd1);
    check("t3_busy", 32'(bus.busy), 32'd0);
    check("t3_no_valid", 32'(bus.out_valid), 32'd0);
    idle(1);
    check("t3_err_cleared", 32'(bus.frame_err), 32'd0);
    exp_q.push_back(32'h89AB);
    beat(2'd0, 4'h8); beat(2'd1, 4'h9); beat(2'd2, 4'hA); beat(2'd3, 4'hB);
    check("t3_clean_out", out_word(), 32'h89AB);
    idle(1);
    check("t3_err_count", 32'(err_cnt - e0), 32'd1);

    // restart on lane 0 mid-frame
    e0 = err_cnt;
    exp_q.push_back(32'h4567);
    beat(2'd0, 4'h1); beat(2'd1, 4'h2); beat(2'd0, 4'h4);
    check("t4_restart_err", 32'(bus.frame_err), 32'd1);
    check("t4_restart_state", 32'(dbg_state), 32'd1);
    beat(2'd1, 4'h5); beat(2'd2, 4'h6); beat(2'd3, 4'h7);
    check("t4_out", out_word(), 32'h4567);
    check("t4_valid", 32'(bus.out_valid), 32'd1);
    idle(1);
    check("t4_err_count", 32'(err_cnt - e0), 32'd1);

    // frame not starting at lane 0
    e0 = err_cnt;
    beat(2'd3, 4'h5);
    check("t5_err", 32'(bus.frame_err), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'd0);
    idle(1);
    check("t5_err_pulse_len", 32'(err_cnt - e0), 32'd1);

    // asynchronous reset mid-frame
    beat(2'd0, 4'h5); beat(2'd1, 4'h6);
    bus.in_valid = 1'b0;
    check("t6_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_out_zero", out_word(), 32'h0000);
    check("t6_busy_zero", 32'(bus.busy), 32'd0);
    check("t6_valid_zero", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    check("t6_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;

    // stalled partial frame
    e0 = err_cnt;
    beat(2'd0, 4'h2);
    idle(15);
    check("t7_busy_15", 32'(bus.busy), 32'd1);
    idle(1);
`ifdef NFD_TIMEOUT_EN
    check("t7_timeout_err", 32'(bus.frame_err), 32'd1);
    check("t7_timeout_busy", 32'(bus.busy), 32'd0);
    idle(1);
    check("t7_err_count", 32'(err_cnt - e0), 32'd1);
`else
    check("t7_no_timeout_err", 32'(bus.frame_err), 32'd0);
    check("t7_no_timeout_busy", 32'(bus.busy), 32'd1);
    idle(1);
    check("t7_err_count", 32'(err_cnt - e0), 32'd0);
`endif
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    idle(1);

    check("sb_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
